// File: rtl/ram21.sv
// -----------------------------------------------------------------------------
// ram21 -- true dual-port RAM with registered read outputs.
//
// Both ports share one 2^ADDR_W x DATA_W array. Each port performs either a
// write or a read at every rising clock edge. The port's wr_x input selects
// the operation.
//
// Behaviour:
//   write : mem[add_x] takes ip_x. q_x holds its previous value, so there is
//           no write-through.
//   read  : q_x takes mem[add_x], giving one cycle of latency.
//   cross-port read of an address written at the same edge returns the old
//   contents (read-before-write).
//   both ports writing the same address at the same edge : port A wins.
//   rst   : clears q_a, q_b and every memory word. A synchronous reset
//           overrides any access in that cycle.
//
// Ports (in positional order):
//   ip_a  [DATA_W-1:0] in   port A write data
//   ip_b  [DATA_W-1:0] in   port B write data
//   add_a [ADDR_W-1:0] in   port A address
//   add_b [ADDR_W-1:0] in   port B address
//   clk                in   clock, rising edge
//   wr_a               in   port A command, 1 = write, 0 = read
//   wr_b               in   port B command, 1 = write, 0 = read
//   q_a   [DATA_W-1:0] out  port A registered read data
//   q_b   [DATA_W-1:0] out  port B registered read data
//   rst                in   synchronous active-high reset
// -----------------------------------------------------------------------------
module ram21 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic [DATA_W-1:0] ip_a,
  input  logic [DATA_W-1:0] ip_b,
  input  logic [ADDR_W-1:0] add_a,
  input  logic [ADDR_W-1:0] add_b,
  input  logic              clk,
  input  logic              wr_a,
  input  logic              wr_b,
  output logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] q_b,
  input  logic              rst
);

  localparam int DEPTH = 1 << ADDR_W;

  // Every ADDR_W-bit value indexes a real word, so no range check is needed.
  logic [DATA_W-1:0] mem [DEPTH];

  // Read data registers.
  // NOTE: non-blocking assignments make both reads sample the array as it was
  // before this edge. That is what gives read-before-write across ports
  // without any explicit bypass logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      if (!wr_a) q_a <= mem[add_a];
      if (!wr_b) q_b <= mem[add_b];
    end
  end

  // Array update.
  // NOTE: the whole array must read as zero after reset, so the memory is
  // cleared here rather than left uninitialised. This forces a register-based
  // implementation instead of a block-RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // Port B is written first so that port A's assignment, being later in
      // the block, wins when both ports target the same address.
      if (wr_b) mem[add_b] <= ip_b;
      if (wr_a) mem[add_a] <= ip_a;
    end
  end

endmodule

// File: tb/tb_ram21.sv
// -----------------------------------------------------------------------------
// tb_ram21 -- self-checking bench for ram21.
//
// A behavioural model holds the RAM as a plain array plus the two expected
// output values. After every clock edge, the model applies the edge's
// operations in order: reset, then reads of the old contents, then the B
// write, then the A write. Both DUT outputs are then compared with the model.
//
// The bench runs the directed scenarios first and then a randomised phase.
// The randomised phase crowds the addresses so that collisions are frequent
// and inserts occasional resets.
// -----------------------------------------------------------------------------
module tb_ram21;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] ip_a, ip_b;
  logic [AW-1:0] add_a, add_b;
  logic          wr_a, wr_b;
  logic [DW-1:0] q_a, q_b;

  ram21 #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .ip_a  (ip_a),
    .ip_b  (ip_b),
    .add_a (add_a),
    .add_b (add_b),
    .clk   (clk),
    .wr_a  (wr_a),
    .wr_b  (wr_b),
    .q_a   (q_a),
    .q_b   (q_b),
    .rst   (rst)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_qa, ref_qb;

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Apply one cycle of stimulus, advance the model, and compare both outputs.
  task automatic step(input logic r,
                      input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                      input string tag);
    logic [DW-1:0] old_a, old_b;
    rst   = r;
    wr_a  = wa; add_a = aa; ip_a = da;
    wr_b  = wb; add_b = ab; ip_b = db;
    @(posedge clk);
    #1;
    if (r) begin
      foreach (ref_mem[i]) ref_mem[i] = '0;
      ref_qa = '0;
      ref_qb = '0;
    end else begin
      old_a = ref_mem[aa];
      old_b = ref_mem[ab];
      if (!wa) ref_qa = old_a;
      if (!wb) ref_qb = old_b;
      if (wb) ref_mem[ab] = db;
      if (wa) ref_mem[aa] = da;
    end
    check({tag, "_qa"}, q_a, ref_qa);
    check({tag, "_qb"}, q_b, ref_qb);
  endtask

  initial begin
    rst = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
    add_a = '0; add_b = '0; ip_a = '0; ip_b = '0;
    #2;

    // Reset while both ports try to write, then read address 0 on both ports.
    step(1, 1, 6'd0, 8'hFF, 1, 6'd0, 8'hEE, "rst0");
    step(0, 0, 6'd0, 8'h00, 0, 6'd0, 8'h00, "rd0");
    check("rd0_const_a", q_a, 8'h00);
    check("rd0_const_b", q_b, 8'h00);

    // Both ports write address 0; port A must win.
    step(0, 1, 6'd0, 8'h01, 1, 6'd0, 8'h11, "wcol");
    step(0, 0, 6'd0, 8'h00, 0, 6'd0, 8'h00, "rcol");
    check("col_a_wins", q_a, 8'h01);

    // A writes address 1 while B reads address 0, then B reads address 1.
    step(0, 1, 6'd1, 8'h02, 0, 6'd0, 8'h00, "e1");
    check("e1_qb", q_b, 8'h01);
    step(0, 0, 6'd0, 8'h00, 0, 6'd1, 8'h00, "e2");
    check("e2_qb", q_b, 8'h02);

    // Fill addresses 2..6 through port A, then read them back in pairs.
    for (int i = 0; i < 5; i++)
      step(0, 1, AW'(i + 2), DW'(i + 3), 0, 6'd0, 8'h00, "fill");
    step(0, 0, 6'd2, 8'h00, 0, 6'd2, 8'h00, "p22");
    check("p22_a", q_a, 8'h03);
    check("p22_b", q_b, 8'h03);
    step(0, 0, 6'd3, 8'h00, 0, 6'd4, 8'h00, "p34");
    check("p34_a", q_a, 8'h04);
    check("p34_b", q_b, 8'h05);
    step(0, 0, 6'd5, 8'h00, 0, 6'd6, 8'h00, "p56");
    check("p56_a", q_a, 8'h06);
    check("p56_b", q_b, 8'h07);

    // Read-before-write across ports at address 9; q_a holds during its write.
    step(0, 0, 6'd9, 8'h00, 0, 6'd9, 8'h00, "pre9");
    step(0, 1, 6'd9, 8'hAA, 0, 6'd9, 8'h00, "rbw9");
    check("rbw9_old_b", q_b, 8'h00);
    check("rbw9_hold_a", q_a, 8'h00);
    step(0, 0, 6'd3, 8'h00, 0, 6'd9, 8'h00, "new9");
    check("new9_b", q_b, 8'hAA);

    // Reset while both ports write, then sweep the whole array on both ports.
    step(1, 1, 6'd3, 8'h55, 1, 6'd4, 8'h66, "rst1");
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, AW'(i), 8'h00, 0, AW'(DEPTH - 1 - i), 8'h00, "sweep");
      check("sweep_a_zero", q_a, 8'h00);
      check("sweep_b_zero", q_b, 8'h00);
    end

    // Randomised phase. Addresses are often crowded into 0..3 to force
    // collisions, and an occasional reset is inserted.
    for (int n = 0; n < 3000; n++) begin
      logic          r, wa, wb;
      logic [AW-1:0] aa, ab;
      logic [DW-1:0] da, db;
      r  = ($urandom_range(0, 63) == 0);
      wa = $urandom_range(0, 1);
      wb = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        aa = AW'($urandom_range(0, 3));
        ab = AW'($urandom_range(0, 3));
      end else begin
        aa = AW'($urandom);
        ab = AW'($urandom);
      end
      da = DW'($urandom);
      db = DW'($urandom);
      step(r, wa, aa, da, wb, ab, db, "rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
